execute_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit, parametrised in datapath width and bits-per-cycle. It sits beside the ALU in the Execute stage and takes fully resolved operands, after forwarding. It holds the front of the pipeline stalled while an operation iterates, then presents a registered result with `rd` for the MEM stage. Divide-by-zero and signed overflow take a one-cycle fast path.

---
 rtl/execute_muldiv.sv | 166 ++++++++++++++++
 tb/tb_execute_muldiv.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the Execute stage: shift-add multiply,
// restoring divide, UNROLL steps per clock, one-cycle fast path for div-by-zero/overflow.
module execute_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  localparam int ITER = XLEN / UNROLL;
  localparam int CW   = $clog2(ITER + 1);
  localparam int AW   = 2 * XLEN + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [XLEN-1:0] opnd;
  logic [2:0]      func3_q;
  logic            neg_q;
  logic [4:0]      rd_q;

  // Accept-side decode of the incoming instruction
  logic            a_signed, b_signed, a_neg, b_neg, neg_res;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_result;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (i_func3)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                         a_signed = 1'b1;
      default:                        ;
    endcase
    a_neg = a_signed & i_rs1_data[XLEN-1];
    b_neg = b_signed & i_rs2_data[XLEN-1];
    a_mag = a_neg ? -i_rs1_data : i_rs1_data;
    b_mag = b_neg ? -i_rs2_data : i_rs2_data;
    // Remainder takes the dividend's sign; everything else the product/quotient sign
    neg_res = (i_func3[2] && i_func3[1]) ? a_neg : (a_neg ^ b_neg);

    div_zero = i_func3[2] && (i_rs2_data == '0);
    div_ovf  = i_func3[2] && !i_func3[0] && (i_rs1_data == MIN_NEG) && (i_rs2_data == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_result = i_func3[1] ? i_rs1_data : '1;
    else          fast_result = i_func3[1] ? '0 : i_rs1_data;
  end

  // UNROLL iteration steps on the shared accumulator.
  // Multiply: acc = {hi(XLEN+1), multiplier}, opnd = multiplicand.
  // Divide:   acc = {rem(XLEN+1), quotient},  opnd = divisor.
  logic [AW-1:0]   acc_step;
  logic [XLEN:0]   hi, trial;

  always_comb begin
    acc_step = acc;
    hi       = '0;
    trial    = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (!func3_q[2]) begin
        hi = acc_step[AW-1:XLEN];
        if (acc_step[0]) hi = hi + {1'b0, opnd};
        acc_step = {hi, acc_step[XLEN-1:0]} >> 1;
      end else begin
        acc_step = acc_step << 1;
        trial    = acc_step[AW-1:XLEN] - {1'b0, opnd};
        if (!trial[XLEN]) begin
          acc_step[AW-1:XLEN] = trial;
          acc_step[0]         = 1'b1;
        end
      end
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_result;

  always_comb begin
    prod_s = neg_q ? -acc_step[2*XLEN-1:0] : acc_step[2*XLEN-1:0];
    quo_s  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_s  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (func3_q)
      3'b000:                 final_result = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_result = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_result = quo_s;
      default:                final_result = rem_s;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      func3_q  <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_rd     <= '0;
    end else if (i_flush) begin
      state   <= IDLE;
      cnt     <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            func3_q <= i_func3;
            neg_q   <= neg_res;
            rd_q    <= i_rd;
            if (fast) begin
              o_result <= fast_result;
              o_rd     <= i_rd;
              o_valid  <= 1'b1;
              state    <= DONE;
            end else begin
              acc   <= i_func3[2] ? {{(XLEN+1){1'b0}}, a_mag} : {{(XLEN+1){1'b0}}, b_mag};
              opnd  <= i_func3[2] ? b_mag : a_mag;
              cnt   <= CW'(ITER);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            o_result <= final_result;
            o_rd     <= rd_q;
            o_valid  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready = (state == IDLE);
  assign o_stall = rst_n && !i_flush && (((state == IDLE) && i_valid) || (state == BUSY));

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench: UNROLL=1 and UNROLL=4 instances share stimulus and are
// compared against a 64-bit arithmetic reference model of RV32M semantics.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_flush;
  logic [2:0]  i_func3;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic [4:0]  i_rd;

  logic        o_ready1, o_stall1, o_valid1, o_ready4, o_stall4, o_valid4;
  logic [31:0] o_result1, o_result4;
  logic [4:0]  o_rd1, o_rd4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(32), .UNROLL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_func3(i_func3),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rd(i_rd), .i_flush(i_flush),
    .o_ready(o_ready1), .o_stall(o_stall1), .o_valid(o_valid1),
    .o_result(o_result1), .o_rd(o_rd1)
  );

  execute_muldiv #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_func3(i_func3),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rd(i_rd), .i_flush(i_flush),
    .o_ready(o_ready4), .o_stall(o_stall4), .o_valid(o_valid4),
    .o_result(o_result4), .o_rd(o_rd4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = 0;
    ub[31:0] = b;
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffff_ffff;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return a;
        q = sa / sb; p = q; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at the current negedge (cycle 0) and observe both units.
  // flush_cyc < 0 means no flush; the task returns at a negedge with both units idle.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int flush_cyc);
    logic [31:0] exp, prev1, res1, res4;
    logic [4:0]  rd1, rd4;
    logic        fast, want1, want4, es1, es4;
    int lat1, lat4, end_cyc, n_v1, n_v4, v1_cyc, v4_cyc, bad1, bad4;
    exp   = model(f, a, b);
    fast  = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hffff_ffff));
    lat1  = fast ? 1 : 33;
    lat4  = fast ? 1 : 9;
    want1 = (flush_cyc < 0) || (lat1 < flush_cyc);
    want4 = (flush_cyc < 0) || (lat4 < flush_cyc);
    end_cyc = (flush_cyc >= 0) ? flush_cyc + 1 : lat1 + 1;
    prev1 = o_result1;
    n_v1 = 0; n_v4 = 0; v1_cyc = -1; v4_cyc = -1; bad1 = 0; bad4 = 0;
    res1 = '0; res4 = '0; rd1 = '0; rd4 = '0;
    i_valid = 1'b1; i_func3 = f; i_rs1_data = a; i_rs2_data = b; i_rd = rd; i_flush = 1'b0;
    for (int cyc = 0; cyc <= end_cyc; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        i_valid = 1'b0;
        i_flush = (cyc == flush_cyc);
      end
      #1;
      es1 = (flush_cyc >= 0 && cyc >= flush_cyc) ? 1'b0 : (cyc < lat1);
      es4 = (flush_cyc >= 0 && cyc >= flush_cyc) ? 1'b0 : (cyc < lat4);
      if (o_stall1 !== es1) bad1++;
      if (o_stall4 !== es4) bad4++;
      if (o_valid1 === 1'b1) begin n_v1++; v1_cyc = cyc; res1 = o_result1; rd1 = o_rd1; end
      if (o_valid4 === 1'b1) begin n_v4++; v4_cyc = cyc; res4 = o_result4; rd4 = o_rd4; end
    end
    check({name, " stall1"}, 32'(bad1), 32'd0);
    check({name, " stall4"}, 32'(bad4), 32'd0);
    check({name, " ready1"}, {31'd0, o_ready1}, 32'd1);
    check({name, " ready4"}, {31'd0, o_ready4}, 32'd1);
    check({name, " nvalid1"}, 32'(n_v1), want1 ? 32'd1 : 32'd0);
    check({name, " nvalid4"}, 32'(n_v4), want4 ? 32'd1 : 32'd0);
    if (want1) begin
      check({name, " vcyc1"}, 32'(v1_cyc), 32'(lat1));
      check({name, " res1"}, res1, exp);
      check({name, " rd1"}, {27'd0, rd1}, {27'd0, rd});
    end else begin
      check({name, " held1"}, o_result1, prev1);
    end
    if (want4) begin
      check({name, " vcyc4"}, 32'(v4_cyc), 32'(lat4));
      check({name, " res4"}, res4, exp);
      check({name, " rd4"}, {27'd0, rd4}, {27'd0, rd});
    end
  endtask

  initial begin
    int nv;
    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_func3 = '0;
    i_rs1_data = '0; i_rs2_data = '0; i_rd = '0;
    #12;
    check("reset result1", o_result1, 32'h0);
    check("reset valid1", {31'd0, o_valid1}, 32'd0);
    check("reset ready4", {31'd0, o_ready4}, 32'd1);
    check("reset stall1", {31'd0, o_stall1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul",     3'd0, 32'd7,          32'hffff_fffd, 5'd3,  -1);
    run_op("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4,  -1);
    run_op("mulhu",   3'd3, 32'h8000_0000,  32'h8000_0000, 5'd5,  -1);
    run_op("mulhsu",  3'd2, 32'hffff_ffff,  32'd2,         5'd6,  -1);
    run_op("div",     3'd4, 32'hffff_fff9,  32'd2,         5'd7,  -1);
    run_op("rem",     3'd6, 32'hffff_fff9,  32'd2,         5'd8,  -1);
    run_op("divu",    3'd5, 32'd100,        32'd7,         5'd9,  -1);
    run_op("remu",    3'd7, 32'd100,        32'd7,         5'd10, -1);
    run_op("div0",    3'd4, 32'd5,          32'd0,         5'd11, -1);
    run_op("rem0",    3'd6, 32'd5,          32'd0,         5'd12, -1);
    run_op("divu0",   3'd5, 32'd5,          32'd0,         5'd13, -1);
    run_op("remu0",   3'd7, 32'd5,          32'd0,         5'd14, -1);
    run_op("divovf",  3'd4, 32'h8000_0000,  32'hffff_ffff, 5'd15, -1);
    run_op("removf",  3'd6, 32'h8000_0000,  32'hffff_ffff, 5'd16, -1);
    run_op("flush",   3'd5, 32'd12345,      32'd67,        5'd17, 10);
    run_op("postfl",  3'd0, 32'h0001_2345,  32'h0000_0678, 5'd18, -1);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick(), pick(),
             5'($urandom_range(0, 31)), -1);
    end

    // Asynchronous reset in the middle of a multiply
    i_valid = 1'b1; i_func3 = 3'd0; i_rs1_data = 32'h1234_5678; i_rs2_data = 32'h9abc_def0; i_rd = 5'd21;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst result1", o_result1, 32'h0);
    check("midrst rd1", {27'd0, o_rd1}, 32'd0);
    check("midrst result4", o_result4, 32'h0);
    check("midrst ready1", {31'd0, o_ready1}, 32'd1);
    check("midrst stall1", {31'd0, o_stall1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (o_valid1 === 1'b1 || o_valid4 === 1'b1) nv++;
    end
    check("midrst novalid", 32'(nv), 32'd0);
    check("midrst ready4", {31'd0, o_ready4}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
